// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// parity mode constants and the parity computation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic even_s;
        even_s = ^data;
        if (mode == PARITY_ODD) begin
            return ~even_s;
        end else begin
            return even_s;
        end
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time down-counter: latches the divisor at frame start (0 acts as 1)
// and pulses tick_o on the last cycle of every bit.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 active_i,
    input  logic                 clear_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] reload_q, reload_d;

    assign tick_o = active_i && (cnt_q == {DIV_WIDTH{1'b0}});

    // Next counter value: load at frame start, reload per bit, rest at 0 when idle.
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            reload_d = (div_i == {DIV_WIDTH{1'b0}}) ? DIV_WIDTH'(1) : div_i;
            cnt_d    = reload_d - DIV_WIDTH'(1);
        end else if (!active_i || clear_i) begin
            cnt_d = {DIV_WIDTH{1'b0}};
        end else if (cnt_q == {DIV_WIDTH{1'b0}}) begin
            cnt_d = reload_q - DIV_WIDTH'(1);
        end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    // Counter and latched reload value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= {DIV_WIDTH{1'b0}};
            reload_q <= DIV_WIDTH'(1);
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity and STOP_BITS stop bits, with bit timing from uart_baud_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divisor,
    uart_tx_if.slave             bus,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, busy_q, done_q, done_d;
    logic                 accept_s, load_s, frame_end_s, tick_s;

    assign accept_s     = bus.tx_valid && ready_q;
    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_s),
        .div_i    (divisor),
        .active_i (state_q != IDLE),
        .clear_i  (frame_end_s),
        .tick_o   (tick_s)
    );

    // Frame sequencing: every state advances only on a bit-time tick.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        frame_end_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                    shreg_d = bus.tx_data;
                    par_d   = parity_bit(9'(bus.tx_data), PARITY);
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d   = DATA;
                    bit_idx_d = 4'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            uart_pkg::PARITY: begin
                if (tick_s) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = uart_pkg::PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        frame_end_s = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state being entered so tx stays registered.
    always_comb begin
        case (state_d)
            START:            tx_d = 1'b0;
            DATA:             tx_d = shreg_d[0];
            uart_pkg::PARITY: tx_d = par_d;
            default:          tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= {DATA_BITS{1'b0}};
            par_q      <= 1'b0;
            bit_idx_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end
endmodule
